vedic_4x4_seq: RTL and testbench



---
 rtl/vedic_4x4_seq.sv | 209 ++++++++++++++++++++
 tb/tb_vedic_4x4_seq.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vedic_4x4_seq.sv
// -----------------------------------------------------------------------------
// vedic_4x4_seq
//
// Sequential 4x4 unsigned multiplier controller around the shared 2x2 Vedic
// multiplier. A 4x4 product is built from four 2x2 sub-products that are issued
// one at a time over the 2x2 unit's start/done handshake. Each returned
// sub-product is shifted into place and added into an 8-bit accumulator.
//
// Sub-product order (aL=a[1:0], aH=a[3:2], same split for b):
//   k=0: aL*bL << 0   k=1: aH*bL << 2   k=2: aL*bH << 2   k=3: aH*bH << 4
//
// Parameters:
//   TIMEOUT  maximum cycles spent waiting for mul_done per sub-product (1..255)
//   CW       width of the timeout counter; must be able to hold TIMEOUT
//
// Ports:
//   clk         system clock, rising edge
//   reset       asynchronous, active-high; clears all state
//   a, b        4-bit operands, sampled when start is accepted in IDLE
//   start       operation request, only accepted in IDLE
//   busy        high from the cycle after acceptance through the done cycle
//   result      8-bit product, valid with done, held until the next operation
//               completes
//   done        one-cycle completion pulse
//   err         set with done when a sub-product timed out; cleared on the
//               next accepted start
//   mul_a/mul_b 2-bit operands to the 2x2 unit, stable from issue to capture
//   mul_start   one-cycle start pulse to the 2x2 unit
//   mul_result  2x2 product, valid while mul_done=1
//   mul_done    2x2 completion
// -----------------------------------------------------------------------------
module vedic_4x4_seq #(
  parameter int unsigned TIMEOUT = 15,
  parameter int unsigned CW      = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       start,
  output logic       busy,
  output logic [7:0] result,
  output logic       done,
  output logic       err,
  output logic [1:0] mul_a,
  output logic [1:0] mul_b,
  output logic       mul_start,
  input  logic [3:0] mul_result,
  input  logic       mul_done
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_FIN   = 2'd3
  } state_e;

  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  // Selects the low or high 2-bit half of a 4-bit operand.
  function automatic logic [1:0] half_sel(input logic [3:0] op, input logic hi);
    half_sel = hi ? op[3:2] : op[1:0];
  endfunction

  // Places a 2x2 sub-product at its weight for the given sub-product index.
  function automatic logic [7:0] place_term(input logic [3:0] p, input logic [1:0] k);
    logic [7:0] t;
    case (k)
      2'd0:       t = {4'b0000, p};
      2'd1, 2'd2: t = {2'b00, p, 2'b00};
      2'd3:       t = {p, 4'b0000};
      default:    t = 8'h00;
    endcase
    return t;
  endfunction

  state_e        state_q;
  logic [3:0]    a_q;
  logic [3:0]    b_q;
  logic [7:0]    acc_q;
  logic [1:0]    k_q;
  logic [CW-1:0] cnt_q;
  logic          busy_q;
  logic          done_q;
  logic          err_q;
  logic [7:0]    result_q;
  logic [1:0]    mul_a_q;
  logic [1:0]    mul_b_q;

  logic [1:0]    k_next_d;
  logic [7:0]    term_d;
  logic [7:0]    acc_d;
  logic [1:0]    nxt_a_d;
  logic [1:0]    nxt_b_d;
  logic          cnt_last_d;

  // Datapath helpers: placed sub-product, running sum and next operand halves.
  always_comb begin
    k_next_d   = k_q + 2'd1;
    term_d     = place_term(mul_result, k_q);
    acc_d      = acc_q + term_d;
    // a uses its high half for odd k, b uses its high half for k >= 2.
    nxt_a_d    = half_sel(a_q, k_next_d[0]);
    nxt_b_d    = half_sel(b_q, k_next_d[1]);
    cnt_last_d = (cnt_q == CNT_LAST);
  end

  // Control FSM with all registered outputs and datapath state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      a_q      <= 4'h0;
      b_q      <= 4'h0;
      acc_q    <= 8'h00;
      k_q      <= 2'd0;
      cnt_q    <= {CW{1'b0}};
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      result_q <= 8'h00;
      mul_a_q  <= 2'd0;
      mul_b_q  <= 2'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            acc_q   <= 8'h00;
            k_q     <= 2'd0;
            cnt_q   <= {CW{1'b0}};
            err_q   <= 1'b0;
            busy_q  <= 1'b1;
            // k=0 operands come straight from the ports being latched.
            mul_a_q <= a[1:0];
            mul_b_q <= b[1:0];
            state_q <= ST_ISSUE;
          end else begin
            state_q <= ST_IDLE;
          end
        end

        ST_ISSUE: begin
          // A done still high from the previous sub-product must drop before
          // issuing, otherwise WAIT would capture it as the new result.
          if (!mul_done) begin
            cnt_q   <= {CW{1'b0}};
            state_q <= ST_WAIT;
          end else begin
            state_q <= ST_ISSUE;
          end
        end

        ST_WAIT: begin
          if (mul_done) begin
            acc_q <= acc_d;
            if (k_q == 2'd3) begin
              // Load the result on the way into FIN so it is valid with done.
              result_q <= acc_d;
              done_q   <= 1'b1;
              state_q  <= ST_FIN;
            end else begin
              k_q     <= k_next_d;
              mul_a_q <= nxt_a_d;
              mul_b_q <= nxt_b_d;
              state_q <= ST_ISSUE;
            end
          end else if (cnt_last_d) begin
            // Timeout: report whatever has been accumulated so far.
            result_q <= acc_q;
            err_q    <= 1'b1;
            done_q   <= 1'b1;
            state_q  <= ST_FIN;
          end else begin
            cnt_q   <= cnt_q + CNT_ONE;
            state_q <= ST_WAIT;
          end
        end

        ST_FIN: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end

        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // mul_start has to be qualified by the current mul_done so that a stale done
  // holds the pulse back in the same cycle; it is decoded from the state
  // register and the 2x2 unit's done rather than registered.
  assign mul_start = (state_q == ST_ISSUE) & ~mul_done;

  assign busy   = busy_q;
  assign done   = done_q;
  assign err    = err_q;
  assign result = result_q;
  assign mul_a  = mul_a_q;
  assign mul_b  = mul_b_q;

endmodule

// File: tb/tb_vedic_4x4_seq.sv
// -----------------------------------------------------------------------------
// tb_vedic_4x4_seq
//
// Directed bench for vedic_4x4_seq. A behavioural 2x2 multiplier answers each
// mul_start with mul_done two cycles later; it can also hold mul_done high for
// extra cycles or never answer. All observation happens 1 time unit after the
// falling clock edge.
// -----------------------------------------------------------------------------
module tb_vedic_4x4_seq;

  localparam int TIMEOUT = 15;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] a = 4'h0;
  logic [3:0] b = 4'h0;
  logic       start = 1'b0;
  logic       busy;
  logic [7:0] result;
  logic       done;
  logic       err;
  logic [1:0] mul_a;
  logic [1:0] mul_b;
  logic       mul_start;
  logic [3:0] mul_result = 4'h0;
  logic       mul_done = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  // 2x2 model configuration, written by the stimulus.
  int   hold_cfg = 0;
  logic never_cfg = 1'b0;

  logic [1:0] m_a = 2'd0;
  logic [1:0] m_b = 2'd0;
  logic       m_stage = 1'b0;
  int         m_hold = 0;

  logic [3:0] iss_q[$];
  int         iss_cyc[$];

  vedic_4x4_seq #(.TIMEOUT(TIMEOUT), .CW(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .a          (a),
    .b          (b),
    .start      (start),
    .busy       (busy),
    .result     (result),
    .done       (done),
    .err        (err),
    .mul_a      (mul_a),
    .mul_b      (mul_b),
    .mul_start  (mul_start),
    .mul_result (mul_result),
    .mul_done   (mul_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural 2x2 unit: start seen at edge n gives done in the cycle after
  // edge n+1 (latency 2); done then stays high for hold_cfg extra cycles.
  always @(posedge clk) begin
    if (m_stage) begin
      mul_done   <= 1'b1;
      mul_result <= {2'b00, m_a} * {2'b00, m_b};
      m_stage    <= 1'b0;
      m_hold     <= hold_cfg;
    end else if (mul_done) begin
      if (m_hold > 0) m_hold <= m_hold - 1;
      else mul_done <= 1'b0;
    end
    if (mul_start && !never_cfg) begin
      m_a     <= mul_a;
      m_b     <= mul_b;
      m_stage <= 1'b1;
    end
  end

  // Log every issued sub-product as {mul_a, mul_b} with its cycle number.
  always @(negedge clk) begin
    if (mul_start === 1'b1) begin
      iss_q.push_back({mul_a, mul_b});
      iss_cyc.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic do_start(input logic [3:0] av, input logic [3:0] bv, output int scyc);
    a = av;
    b = bv;
    start = 1'b1;
    scyc = cyc;
    step();
    start = 1'b0;
  endtask

  // Waits for done; optionally pulses a foreign start (F x F) at loop index
  // inject, and counts cycles in which busy was not high.
  task automatic wait_done(input string tag, input int inject, output int dcyc, output int busy_lows);
    dcyc = -1;
    busy_lows = 0;
    for (int i = 0; (i < 300) && (dcyc < 0); i++) begin
      if (busy !== 1'b1) busy_lows++;
      if (done === 1'b1) begin
        dcyc = cyc;
      end else begin
        if (i == inject) begin
          a = 4'hF;
          b = 4'hF;
          start = 1'b1;
        end else begin
          start = 1'b0;
        end
        step();
      end
    end
    start = 1'b0;
    check({tag, "_done_seen"}, (dcyc >= 0) ? 32'd1 : 32'd0, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int scyc;
    int dcyc;
    int bl;
    int base;
    int n0;
    logic [3:0] exp_iss[4];

    // ---------------- reset state ----------------
    #1 reset = 1'b1;
    #2;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_result", result, 8'h00);
    check("rst_mul_start", mul_start, 1'b0);
    check("rst_mul_ab", {mul_a, mul_b}, 4'h0);
    step();
    step();
    reset = 1'b0;
    step();

    // ---------------- 15 x 15, latency ----------------
    base = iss_q.size();
    do_start(4'hF, 4'hF, scyc);
    wait_done("t1", -1, dcyc, bl);
    check("t1_result", result, 8'hE1);
    check("t1_err", err, 1'b0);
    // start cycle through done cycle inclusive: 1 + 4*(1+2) + 1
    check("t1_latency", dcyc - scyc + 1, 14);
    check("t1_issues", iss_q.size() - base, 4);
    for (int j = 0; j < 4; j++) check($sformatf("t1_iss%0d", j), iss_q[base + j], 4'hF);
    step();
    check("t1_done_pulse", done, 1'b0);
    check("t1_busy_after", busy, 1'b0);
    step();

    // ---------------- 9 x 6, issue order, start while busy ----------------
    exp_iss[0] = 4'h6;  // (1,2)
    exp_iss[1] = 4'hA;  // (2,2)
    exp_iss[2] = 4'h5;  // (1,1)
    exp_iss[3] = 4'h9;  // (2,1)
    base = iss_q.size();
    do_start(4'b1001, 4'b0110, scyc);
    wait_done("t2", 4, dcyc, bl);
    check("t2_result", result, 8'd54);
    check("t2_busy_lows", bl, 0);
    check("t2_issues", iss_q.size() - base, 4);
    for (int j = 0; j < 4; j++) check($sformatf("t2_iss%0d", j), iss_q[base + j], exp_iss[j]);
    // start presented in the FIN (done) cycle must be ignored
    a = 4'hF;
    b = 4'hF;
    start = 1'b1;
    step();
    start = 1'b0;
    check("t2_fin_start_busy", busy, 1'b0);
    n0 = iss_q.size();
    repeat (4) step();
    check("t2_fin_start_noissue", iss_q.size() - n0, 0);
    check("t2_result_held", result, 8'd54);

    // ---------------- 0 x A, then back-to-back 3 x 5 ----------------
    do_start(4'h0, 4'hA, scyc);
    wait_done("t3a", -1, dcyc, bl);
    check("t3a_result", result, 8'h00);
    step();
    check("t3a_done_pulse", done, 1'b0);
    do_start(4'h3, 4'h5, scyc);
    wait_done("t3b", -1, dcyc, bl);
    check("t3b_result", result, 8'd15);
    check("t3b_latency", dcyc - scyc + 1, 14);
    step();
    step();

    // ---------------- stale done drain, 7 x 9 ----------------
    hold_cfg = 3;
    base = iss_q.size();
    do_start(4'h7, 4'h9, scyc);
    wait_done("t4", -1, dcyc, bl);
    check("t4_result", result, 8'd63);
    check("t4_issues", iss_q.size() - base, 4);
    // each later issue waits out 3 extra done cycles: 1 + 3 + 3*6 + 1
    check("t4_latency", dcyc - scyc + 1, 23);
    hold_cfg = 0;
    repeat (6) step();
    check("t4_result_held", result, 8'd63);

    // ---------------- timeout ----------------
    never_cfg = 1'b1;
    base = iss_q.size();
    do_start(4'h6, 4'h7, scyc);
    wait_done("t5", -1, dcyc, bl);
    check("t5_err", err, 1'b1);
    check("t5_result", result, 8'h00);
    check("t5_issues", iss_q.size() - base, 1);
    // cycles spent waiting between the mul_start cycle and the done cycle
    check("t5_wait_cycles", dcyc - iss_cyc[base] - 1, TIMEOUT);
    step();
    check("t5_done_pulse", done, 1'b0);
    check("t5_err_held", err, 1'b1);
    never_cfg = 1'b0;
    step();
    do_start(4'h2, 4'h3, scyc);
    check("t5_err_cleared", err, 1'b0);
    wait_done("t5b", -1, dcyc, bl);
    check("t5b_result", result, 8'd6);
    check("t5b_err", err, 1'b0);
    step();

    // ---------------- async reset in WAIT with k=2 ----------------
    base = iss_q.size();
    do_start(4'hB, 4'hE, scyc);
    for (int i = 0; (i < 50) && (iss_q.size() - base < 3); i++) step();
    check("t6_reach_k2", iss_q.size() - base, 3);
    step();
    check("t6_pre_busy", busy, 1'b1);
    check("t6_pre_mul_ab", {mul_a, mul_b}, 4'hF);
    #1 reset = 1'b1;
    #1;
    check("t6_rst_busy", busy, 1'b0);
    check("t6_rst_result", result, 8'h00);
    check("t6_rst_mul_ab", {mul_a, mul_b}, 4'h0);
    check("t6_rst_mul_start", mul_start, 1'b0);
    check("t6_rst_done_err", {done, err}, 2'b00);
    reset = 1'b0;
    n0 = iss_q.size();
    repeat (4) begin
      step();
      check("t6_idle_done", done, 1'b0);
      check("t6_idle_busy", busy, 1'b0);
    end
    check("t6_late_noissue", iss_q.size() - n0, 0);
    do_start(4'h5, 4'h5, scyc);
    wait_done("t6", -1, dcyc, bl);
    check("t6_result", result, 8'd25);
    check("t6_err", err, 1'b0);
    check("t6_latency", dcyc - scyc + 1, 14);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
